// File: rtl/tm1638_responder.sv
// rtl/tm1638_responder.sv - device-side TM1638 serial endpoint (display RAM writes, control, key reads)
module tm1638_responder #(
   parameter int ram_bytes = 16,
   parameter int key_bytes = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sio_clk,
   input  logic                   sio_stb,
   input  logic                   sio_data_in,
   output logic                   sio_data_out,
   output logic                   sio_data_oe,
   input  logic [8*key_bytes-1:0] keys,
   output logic [8*ram_bytes-1:0] display,
   output logic                   display_on,
   output logic [2:0]             brightness,
   output logic                   frame_done
);

   localparam int aw    = (ram_bytes > 1) ? $clog2(ram_bytes) : 1;
   localparam int kbits = 8 * key_bytes;
   localparam int rw    = $clog2(kbits + 1);

   localparam logic [aw-1:0] addr_mask = aw'(ram_bytes - 1);
   localparam logic [aw-1:0] addr_last = aw'(ram_bytes - 1);
   localparam logic [rw-1:0] rd_total  = rw'(kbits);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_WDATA,
      S_READ,
      S_IGNORE
   } state_t;

   // Pin conditioning registers: two-stage synchronizers plus one history stage each.
   logic [1:0] clk_sync_q;
   logic       clk_hist_q;
   logic [1:0] stb_sync_q;
   logic       stb_hist_q;
   logic       stb_seen_q;
   logic [1:0] dat_sync_q;

   // Protocol state.
   state_t                 state_q;
   logic [2:0]             bit_cnt_q;
   logic [6:0]             shift_q;
   logic [kbits-1:0]       key_sr_q;
   logic [rw-1:0]          rd_cnt_q;
   logic [aw-1:0]          addr_q;
   logic                   fixed_q;
   logic [8*ram_bytes-1:0] display_q;
   logic                   on_q;
   logic [2:0]             bright_q;
   logic                   oe_q;
   logic                   out_q;
   logic                   done_q;

   // Combinational event decode and next-values.
   logic          clk_s;
   logic          stb_s;
   logic          dat_s;
   logic          stb_fall;
   logic          stb_rise;
   logic          sclk_rise;
   logic          sclk_fall;
   logic [7:0]    byte_d;
   logic [aw-1:0] addr_d;

   assign clk_s = clk_sync_q[1];
   assign stb_s = stb_sync_q[1];
   assign dat_s = dat_sync_q[1];

   // Strobe edges only count once the strobe has been seen high since reset,
   // so a frame already in progress when reset releases is never joined.
   assign stb_fall = stb_seen_q & stb_hist_q & ~stb_s;
   assign stb_rise = stb_seen_q & ~stb_hist_q & stb_s;

   // Serial clock edges are only meaningful while the strobe is held low.
   assign sclk_rise = ~stb_s & clk_s & ~clk_hist_q;
   assign sclk_fall = ~stb_s & ~clk_s & clk_hist_q;

   // LSB-first assembly: the newest bit lands in the MSB.
   assign byte_d = {dat_s, shift_q};

   assign addr_d = (addr_q == addr_last) ? '0 : addr_q + aw'(1);

   // Synchronize the three master pins and keep one cycle of history for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q <= 2'b11;
         clk_hist_q <= 1'b1;
         stb_sync_q <= 2'b00;
         stb_hist_q <= 1'b0;
         stb_seen_q <= 1'b0;
         dat_sync_q <= 2'b11;
      end else begin
         clk_sync_q <= {clk_sync_q[0], sio_clk};
         clk_hist_q <= clk_sync_q[1];
         stb_sync_q <= {stb_sync_q[0], sio_stb};
         stb_hist_q <= stb_sync_q[1];
         stb_seen_q <= stb_seen_q | stb_sync_q[1];
         dat_sync_q <= {dat_sync_q[0], sio_data_in};
      end
   end

   // Frame state machine with registered display, control and DIO outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= 3'd0;
         shift_q   <= 7'd0;
         key_sr_q  <= '0;
         rd_cnt_q  <= '0;
         addr_q    <= '0;
         fixed_q   <= 1'b0;
         display_q <= '0;
         on_q      <= 1'b0;
         bright_q  <= 3'd0;
         oe_q      <= 1'b0;
         out_q     <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (stb_rise) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            oe_q      <= 1'b0;
            out_q     <= 1'b1;
            done_q    <= 1'b1;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (stb_fall) begin
                     bit_cnt_q <= 3'd0;
                     state_q   <= S_CMD;
                  end
               end
               S_CMD: begin
                  if (sclk_rise) begin
                     shift_q   <= byte_d[7:1];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        case (byte_d[7:6])
                           2'b01: begin
                              if (byte_d[1]) begin
                                 key_sr_q <= keys;
                                 rd_cnt_q <= '0;
                                 state_q  <= S_READ;
                              end else begin
                                 fixed_q <= byte_d[2];
                                 state_q <= S_IGNORE;
                              end
                           end
                           2'b10: begin
                              on_q     <= byte_d[3];
                              bright_q <= byte_d[2:0];
                              state_q  <= S_IGNORE;
                           end
                           2'b11: begin
                              addr_q  <= byte_d[aw-1:0] & addr_mask;
                              state_q <= S_WDATA;
                           end
                           default: state_q <= S_IGNORE;
                        endcase
                     end
                  end
               end
               S_WDATA: begin
                  if (sclk_rise) begin
                     shift_q   <= byte_d[7:1];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        for (int i = 0; i < ram_bytes; i++) begin
                           if (addr_q == aw'(i)) begin
                              display_q[8*i +: 8] <= byte_d;
                           end
                        end
                        if (!fixed_q) begin
                           addr_q <= addr_d;
                        end
                     end
                  end
               end
               S_READ: begin
                  if (sclk_fall) begin
                     if (rd_cnt_q != rd_total) begin
                        oe_q     <= 1'b1;
                        out_q    <= key_sr_q[0];
                        key_sr_q <= key_sr_q >> 1;
                        rd_cnt_q <= rd_cnt_q + rw'(1);
                     end else begin
                        oe_q  <= 1'b0;
                        out_q <= 1'b1;
                     end
                  end
               end
               S_IGNORE: begin
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign sio_data_out = out_q;
   assign sio_data_oe  = oe_q;
   assign display      = display_q;
   assign display_on   = on_q;
   assign brightness   = bright_q;
   assign frame_done   = done_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// tb/tb_tm1638_responder.sv - self-checking bench for tm1638_responder
module tb_tm1638_responder;

   localparam int HALF = 50;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         sio_clk = 1'b1;
   logic         sio_stb = 1'b1;
   logic         sio_data_in = 1'b1;
   logic         sio_data_out;
   logic         sio_data_oe;
   logic [31:0]  keys = 32'h0;
   logic [127:0] display;
   logic         display_on;
   logic [2:0]   brightness;
   logic         frame_done;

   always #5 clk = ~clk;

   tm1638_responder #(.ram_bytes(16), .key_bytes(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sio_clk      (sio_clk),
      .sio_stb      (sio_stb),
      .sio_data_in  (sio_data_in),
      .sio_data_out (sio_data_out),
      .sio_data_oe  (sio_data_oe),
      .keys         (keys),
      .display      (display),
      .display_on   (display_on),
      .brightness   (brightness),
      .frame_done   (frame_done)
   );

   int total = 0;
   int passed = 0;

   int   fd_count = 0;
   int   fd_double = 0;
   logic fd_prev = 1'b0;

   always @(negedge clk) begin
      if (frame_done) fd_count <= fd_count + 1;
      if (frame_done && fd_prev) fd_double <= fd_double + 1;
      fd_prev <= frame_done;
   end

   // Reference model of the device state, updated per completed frame.
   logic [7:0] m_ram[16];
   logic       m_fixed;
   int         m_addr;
   logic       m_on;
   logic [2:0] m_br;
   int         m_frames;
   logic [7:0] fq[$];

   function automatic void m_reset();
      for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
      m_fixed = 1'b0;
      m_addr  = 0;
      m_on    = 1'b0;
      m_br    = 3'd0;
   endfunction

   function automatic logic [127:0] m_display();
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = m_ram[i];
      return r;
   endfunction

   function automatic void m_apply();
      logic [7:0] c;
      if (fq.size() == 0) return;
      c = fq[0];
      case (c[7:6])
         2'b01: if (!c[1]) m_fixed = c[2];
         2'b10: begin
            m_on = c[3];
            m_br = c[2:0];
         end
         2'b11: begin
            m_addr = int'(c[3:0]);
            for (int k = 1; k < fq.size(); k++) begin
               m_ram[m_addr] = fq[k];
               if (!m_fixed) m_addr = (m_addr + 1) % 16;
            end
         end
         default: ;
      endcase
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic frame_begin();
      sio_stb = 1'b0;
      #(HALF);
   endtask

   task automatic frame_end();
      #(HALF);
      sio_stb = 1'b1;
      #(3*HALF);
      m_frames++;
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         sio_clk = 1'b0;
         sio_data_in = b[i];
         #(HALF);
         sio_clk = 1'b1;
         #(HALF);
      end
      sio_data_in = 1'b1;
   endtask

   task automatic read_byte(output logic [7:0] b, output logic oe_all, output logic oe_any);
      oe_all = 1'b1;
      oe_any = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sio_clk = 1'b0;
         #(HALF);
         b[i] = sio_data_out;
         oe_all = oe_all & sio_data_oe;
         oe_any = oe_any | sio_data_oe;
         sio_clk = 1'b1;
         #(HALF);
      end
   endtask

   task automatic write_frame(input int partial);
      frame_begin();
      foreach (fq[i]) send_bits(fq[i], 8);
      if (partial > 0) send_bits(8'($urandom), partial);
      frame_end();
      m_apply();
   endtask

   task automatic check_model(input string tag);
      check({tag, "_display"}, display, m_display());
      check({tag, "_on"}, 128'(display_on), 128'(m_on));
      check({tag, "_bright"}, 128'(brightness), 128'(m_br));
      check({tag, "_oe_idle"}, 128'(sio_data_oe), 128'(0));
   endtask

   task automatic read_frame(input logic [7:0] cmd, input int nread, input bit change_keys,
                             input bit extra_fall);
      logic [31:0] snap;
      logic [7:0]  b;
      logic        oe_all, oe_any;
      frame_begin();
      send_bits(cmd, 8);
      snap = keys;
      for (int j = 0; j < nread; j++) begin
         read_byte(b, oe_all, oe_any);
         check("read_byte", 128'(b), 128'(snap[8*j +: 8]));
         check("read_oe", 128'(oe_all), 128'(1));
         if (change_keys) keys = $urandom;
      end
      if (extra_fall) begin
         sio_clk = 1'b0;
         #(HALF);
         check("release_oe", 128'(sio_data_oe), 128'(0));
         check("release_out", 128'(sio_data_out), 128'(1));
         sio_clk = 1'b1;
         #(HALF);
      end
      frame_end();
   endtask

   typedef struct {
      logic [7:0] b[4];
      int         n;
      int         idx;
      logic [7:0] exp_byte;
      logic       exp_on;
      logic [2:0] exp_br;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic [7:0] b;
      logic       oe_all, oe_any;
      int         fd_base;
      int         kind;

      vecs[0]  = '{'{8'h40, 8'h00, 8'h00, 8'h00}, 1, 0,  8'h00, 1'b0, 3'd0};
      vecs[1]  = '{'{8'hC0, 8'h11, 8'h22, 8'h33}, 4, 2,  8'h33, 1'b0, 3'd0};
      vecs[2]  = '{'{8'h44, 8'h00, 8'h00, 8'h00}, 1, 1,  8'h22, 1'b0, 3'd0};
      vecs[3]  = '{'{8'hC5, 8'hAA, 8'hBB, 8'h00}, 3, 5,  8'hBB, 1'b0, 3'd0};
      vecs[4]  = '{'{8'h00, 8'h00, 8'h00, 8'h00}, 1, 4,  8'h00, 1'b0, 3'd0};
      vecs[5]  = '{'{8'h00, 8'h00, 8'h00, 8'h00}, 1, 6,  8'h00, 1'b0, 3'd0};
      vecs[6]  = '{'{8'h40, 8'h00, 8'h00, 8'h00}, 1, 0,  8'h11, 1'b0, 3'd0};
      vecs[7]  = '{'{8'hCF, 8'h01, 8'h02, 8'h00}, 3, 15, 8'h01, 1'b0, 3'd0};
      vecs[8]  = '{'{8'h00, 8'h00, 8'h00, 8'h00}, 1, 0,  8'h02, 1'b0, 3'd0};
      vecs[9]  = '{'{8'h8D, 8'h00, 8'h00, 8'h00}, 1, 15, 8'h01, 1'b1, 3'd5};
      vecs[10] = '{'{8'h80, 8'h00, 8'h00, 8'h00}, 1, 5,  8'hBB, 1'b0, 3'd0};

      m_reset();
      m_frames = 0;

      // Reset values while reset is held.
      #23;
      check("rst_display", display, 128'(0));
      check("rst_on", 128'(display_on), 128'(0));
      check("rst_bright", 128'(brightness), 128'(0));
      check("rst_oe", 128'(sio_data_oe), 128'(0));
      check("rst_out", 128'(sio_data_out), 128'(1));
      check("rst_fd", 128'(frame_done), 128'(0));
      #7;
      rst_n = 1'b1;
      #100;

      // Directed frame table.
      for (int v = 0; v < 11; v++) begin
         fq.delete();
         for (int k = 0; k < vecs[v].n; k++) fq.push_back(vecs[v].b[k]);
         write_frame(0);
         check($sformatf("vec%0d_byte%0d", v, vecs[v].idx),
               128'(display[8*vecs[v].idx +: 8]), 128'(vecs[v].exp_byte));
         check($sformatf("vec%0d_on", v), 128'(display_on), 128'(vecs[v].exp_on));
         check($sformatf("vec%0d_bright", v), 128'(brightness), 128'(vecs[v].exp_br));
         check_model($sformatf("vec%0d", v));
      end
      check("fd_count_table", 128'(fd_count), 128'(m_frames));

      // Key read with mid-read key change and release on the 33rd fall.
      keys = 32'h8001_F00F;
      read_frame(8'h42, 4, 1'b1, 1'b1);
      check_model("read_plan");

      // Strobe raised after 5 bits of a data byte.
      fq.delete();
      fq.push_back(8'hC3);
      write_frame(5);
      check("partial_byte3", 128'(display[8*3 +: 8]), 128'(8'h00));
      fq.delete();
      fq.push_back(8'hC3);
      fq.push_back(8'h77);
      write_frame(0);
      check("after_partial_byte3", 128'(display[8*3 +: 8]), 128'(8'h77));
      // Strobe raised mid-command, then a control frame.
      fq.delete();
      write_frame(5);
      fq.push_back(8'h8B);
      write_frame(0);
      check("after_partial_cmd_on", 128'(display_on), 128'(1));
      check("after_partial_cmd_br", 128'(brightness), 128'(3));
      check_model("partial");

      // Randomized frames against the model.
      for (int it = 0; it < 40; it++) begin
         kind = $urandom_range(0, 4);
         fq.delete();
         case (kind)
            0: begin
               fq.push_back(8'hC0 | 8'($urandom_range(0, 63)));
               for (int k = 0; k < $urandom_range(1, 4); k++) fq.push_back(8'($urandom));
               write_frame($urandom_range(0, 7));
            end
            1: begin
               fq.push_back(8'h40 | (8'($urandom) & 8'h3D));
               write_frame(0);
            end
            2: begin
               fq.push_back(8'h80 | 8'($urandom_range(0, 63)));
               write_frame(0);
            end
            3: begin
               keys = $urandom;
               read_frame(8'h42 | (8'($urandom) & 8'h3D), $urandom_range(0, 4), 1'b1, 1'b0);
            end
            default: begin
               fq.push_back(8'($urandom_range(0, 63)));
               fq.push_back(8'($urandom));
               write_frame(0);
            end
         endcase
         check_model($sformatf("rand%0d", it));
      end
      check("fd_count_all", 128'(fd_count), 128'(m_frames));
      check("fd_width", 128'(fd_double), 128'(0));

      // Reset pulse in the middle of a read.
      keys = 32'h1234_5678;
      frame_begin();
      send_bits(8'h42, 8);
      read_byte(b, oe_all, oe_any);
      check("mid_read_byte0", 128'(b), 128'(8'h78));
      sio_clk = 1'b0;
      #(HALF);
      rst_n = 1'b0;
      #1;
      check("midrst_oe", 128'(sio_data_oe), 128'(0));
      check("midrst_out", 128'(sio_data_out), 128'(1));
      check("midrst_display", display, 128'(0));
      check("midrst_on", 128'(display_on), 128'(0));
      check("midrst_bright", 128'(brightness), 128'(0));
      check("midrst_fd", 128'(frame_done), 128'(0));
      #9;
      sio_clk = 1'b1;
      #(HALF);
      rst_n = 1'b1;
      #(HALF);
      read_byte(b, oe_all, oe_any);
      check("not_joined_oe", 128'(oe_any), 128'(0));
      check("not_joined_out", 128'(b), 128'(8'hFF));
      sio_stb = 1'b1;
      #(3*HALF);
      m_reset();

      fd_base = fd_count;
      fq.delete();
      fq.push_back(8'hC0);
      fq.push_back(8'h5A);
      write_frame(0);
      check("post_rst_byte0", 128'(display[7:0]), 128'(8'h5A));
      check("post_rst_fd", 128'(fd_count - fd_base), 128'(1));
      check_model("post_rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
